// File: rtl/huff_pkg.sv
// huff_pkg: shared constants and types for the serial Huffman decoder.
//   Index map: 0..9 leaves (symbol = index), 10..17 internal nodes Node0..Node7,
//   18..31 illegal. ROOT is an out-of-map code used only as the walk's start point.
//   Node word layout: [14:10] child for bit 0, [9:5] child for bit 1, [4:0] unused.
package huff_pkg;

   localparam int unsigned SYM_W     = 4;
   localparam int unsigned IDX_W     = 5;
   localparam int unsigned MAX_DEPTH = 9;
   localparam int unsigned DEPTH_W   = 4;
   localparam int unsigned NUM_SYM   = 10;
   localparam int unsigned NUM_NODE  = 8;
   localparam int unsigned NODE_BASE = 10;
   localparam int unsigned NODE_W    = 15;

   // Node field slice positions
   localparam int unsigned C0_HI = 14;
   localparam int unsigned C0_LO = 10;
   localparam int unsigned C1_HI = 9;
   localparam int unsigned C1_LO = 5;

   typedef logic [IDX_W-1:0] idx_t;

   // Never produced by the tree, so it cannot alias a leaf or node.
   localparam idx_t ROOT = 5'd31;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StWalk,
      StEmit,
      StErr
   } state_e;

endpackage

// File: rtl/huff_child_sel.sv
// huff_child_sel: combinational child lookup for one tree step.
//   cur        current position (ROOT or 10..17)
//   bit_val    coded bit selecting the branch
//   child0/1   per-node children for bit 0 / bit 1
//   m1, m2     root children for bit 0 / bit 1
//   next       selected child index
//   is_leaf    next is a symbol (0..9)
//   is_illegal next is outside the leaf/node map (18..31)
module huff_child_sel import huff_pkg::*; (
   input  idx_t                cur,
   input  logic                bit_val,
   input  idx_t [NUM_NODE-1:0] child0,
   input  idx_t [NUM_NODE-1:0] child1,
   input  idx_t                m1,
   input  idx_t                m2,
   output idx_t                next,
   output logic                is_leaf,
   output logic                is_illegal
);

   always_comb begin
      next = '0;
      if (cur == ROOT) begin
         next = bit_val ? m2 : m1;
      end else begin
         for (int k = 0; k < NUM_NODE; k++) begin
            if (cur == idx_t'(NODE_BASE + k)) begin
               next = bit_val ? child1[k] : child0[k];
            end
         end
      end
      is_leaf    = (next < idx_t'(NUM_SYM));
      is_illegal = (next >= idx_t'(NODE_BASE + NUM_NODE));
   end

endmodule

// File: rtl/huffman_decoder.sv
// huffman_decoder: serial Huffman decoder for a 10-symbol alphabet.
//   Snapshots the tree (Node0..Node7, m1, m2) one cycle after Start_dec, then
//   walks it one accepted bit per cycle and emits a symbol per completed code.
// Ports:
//   Clk_in, Rst          clock (rising edge), asynchronous active-high reset
//   Start_dec            pulse: abort any walk, reload tree, clear Err/Sym_cnt
//   Node0..Node7, m1, m2 tree inputs, sampled only in the LOAD cycle
//   Bit_in/Bit_valid/Bit_ready   coded bit handshake
//   Sym_out/Sym_valid/Sym_ready  decoded symbol handshake
//   Busy                 tree loaded and not in error
//   Err                  sticky malformed-tree / over-length error
//   Sym_cnt              saturating count of symbols accepted downstream
// Optional feature (macro HUFF_DEC_CODE_LEN_EN): output Code_len, the bit
//   length of the code behind the current Sym_out.
module huffman_decoder import huff_pkg::*; #(
   parameter int unsigned CNT_W = 16
) (
   input  logic                 Clk_in,
   input  logic                 Rst,
   input  logic                 Start_dec,
   input  logic [NODE_W-1:0]    Node0,
   input  logic [NODE_W-1:0]    Node1,
   input  logic [NODE_W-1:0]    Node2,
   input  logic [NODE_W-1:0]    Node3,
   input  logic [NODE_W-1:0]    Node4,
   input  logic [NODE_W-1:0]    Node5,
   input  logic [NODE_W-1:0]    Node6,
   input  logic [NODE_W-1:0]    Node7,
   input  logic [IDX_W-1:0]     m1,
   input  logic [IDX_W-1:0]     m2,
   input  logic                 Bit_in,
   input  logic                 Bit_valid,
   output logic                 Bit_ready,
   output logic [SYM_W-1:0]     Sym_out,
   output logic                 Sym_valid,
   input  logic                 Sym_ready,
   output logic                 Busy,
   output logic                 Err,
   output logic [CNT_W-1:0]     Sym_cnt
`ifdef HUFF_DEC_CODE_LEN_EN
   ,
   output logic [3:0]           Code_len
`endif
);

   state_e               state_q;
   idx_t                 cur_q;
   logic [DEPTH_W-1:0]   depth_q;
   logic [DEPTH_W-1:0]   depth_next;
   idx_t [NUM_NODE-1:0]  child0_q;
   idx_t [NUM_NODE-1:0]  child1_q;
   idx_t                 m1_q;
   idx_t                 m2_q;

   logic [NODE_W-1:0]    node_in [NUM_NODE];
   idx_t                 next;
   logic                 is_leaf;
   logic                 is_illegal;
   logic                 unused_node_lo;

   assign node_in[0] = Node0;
   assign node_in[1] = Node1;
   assign node_in[2] = Node2;
   assign node_in[3] = Node3;
   assign node_in[4] = Node4;
   assign node_in[5] = Node5;
   assign node_in[6] = Node6;
   assign node_in[7] = Node7;

   // Low field of each node word carries nothing for the decoder.
   always_comb begin
      unused_node_lo = 1'b0;
      for (int k = 0; k < NUM_NODE; k++) begin
         unused_node_lo = unused_node_lo ^ (^node_in[k][C1_LO-1:0]);
      end
   end

   assign depth_next = depth_q + DEPTH_W'(1);

   huff_child_sel u_child_sel (
      .cur        (cur_q),
      .bit_val    (Bit_in),
      .child0     (child0_q),
      .child1     (child1_q),
      .m1         (m1_q),
      .m2         (m2_q),
      .next       (next),
      .is_leaf    (is_leaf),
      .is_illegal (is_illegal)
   );

   always_ff @(posedge Clk_in or posedge Rst) begin
      if (Rst) begin
         state_q   <= StIdle;
         cur_q     <= ROOT;
         depth_q   <= '0;
         child0_q  <= '0;
         child1_q  <= '0;
         m1_q      <= '0;
         m2_q      <= '0;
         Bit_ready <= 1'b0;
         Sym_out   <= '0;
         Sym_valid <= 1'b0;
         Busy      <= 1'b0;
         Err       <= 1'b0;
         Sym_cnt   <= '0;
`ifdef HUFF_DEC_CODE_LEN_EN
         Code_len  <= '0;
`endif
      end else if (Start_dec) begin
         // Start wins over any handshake in flight; pending work is dropped.
         state_q   <= StLoad;
         Bit_ready <= 1'b0;
         Sym_valid <= 1'b0;
         Busy      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
            end
            StLoad: begin
               for (int k = 0; k < NUM_NODE; k++) begin
                  child0_q[k] <= node_in[k][C0_HI:C0_LO];
                  child1_q[k] <= node_in[k][C1_HI:C1_LO];
               end
               m1_q      <= m1;
               m2_q      <= m2;
               Err       <= 1'b0;
               Sym_cnt   <= '0;
               depth_q   <= '0;
               cur_q     <= ROOT;
               Bit_ready <= 1'b1;
               Busy      <= 1'b1;
               state_q   <= StWalk;
            end
            StWalk: begin
               if (Bit_valid && Bit_ready) begin
                  depth_q <= depth_next;
                  if (is_leaf) begin
                     Sym_out   <= next[SYM_W-1:0];
                     Sym_valid <= 1'b1;
                     Bit_ready <= 1'b0;
`ifdef HUFF_DEC_CODE_LEN_EN
                     Code_len  <= depth_next;
`endif
                     state_q   <= StEmit;
                  end else if (!is_illegal && (depth_next < DEPTH_W'(MAX_DEPTH))) begin
                     cur_q <= next;
                  end else begin
                     // Bad index or a code that would exceed MAX_DEPTH bits.
                     Err       <= 1'b1;
                     Bit_ready <= 1'b0;
                     Busy      <= 1'b0;
                     state_q   <= StErr;
                  end
               end
            end
            StEmit: begin
               if (Sym_ready) begin
                  if (Sym_cnt != '1) begin
                     Sym_cnt <= Sym_cnt + CNT_W'(1);
                  end
                  Sym_valid <= 1'b0;
                  cur_q     <= ROOT;
                  depth_q   <= '0;
                  Bit_ready <= 1'b1;
                  state_q   <= StWalk;
               end
            end
            StErr: begin
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_huffman_decoder.sv
// tb_huffman_decoder: directed self-checking bench for huffman_decoder.
//   Tree A: m1=10, m2=0, Node_k={k+1, 11+k} for k<7, Node7={8,9}.
//   Codes: 1->0, 00->1, 0 1x7 0->8, 0 1x8->9.
`timescale 1ns/1ps
module tb_huffman_decoder;

   logic        clk;
   logic        rst;
   logic        start_dec;
   logic [14:0] node0, node1, node2, node3, node4, node5, node6, node7;
   logic [4:0]  m1, m2;
   logic        bit_in, bit_valid, bit_ready;
   logic [3:0]  sym_out;
   logic        sym_valid, sym_ready;
   logic        busy, err;
   logic [15:0] sym_cnt;
`ifdef HUFF_DEC_CODE_LEN_EN
   logic [3:0]  code_len;
`endif

   int checks   = 0;
   int failures = 0;

   huffman_decoder dut (
      .Clk_in    (clk),
      .Rst       (rst),
      .Start_dec (start_dec),
      .Node0     (node0),
      .Node1     (node1),
      .Node2     (node2),
      .Node3     (node3),
      .Node4     (node4),
      .Node5     (node5),
      .Node6     (node6),
      .Node7     (node7),
      .m1        (m1),
      .m2        (m2),
      .Bit_in    (bit_in),
      .Bit_valid (bit_valid),
      .Bit_ready (bit_ready),
      .Sym_out   (sym_out),
      .Sym_valid (sym_valid),
      .Sym_ready (sym_ready),
      .Busy      (busy),
      .Err       (err),
      .Sym_cnt   (sym_cnt)
`ifdef HUFF_DEC_CODE_LEN_EN
      ,
      .Code_len  (code_len)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog sim time expired, required finish before 200000ns");
      $fatal(1);
   end

   function automatic logic [14:0] mk_node(input logic [4:0] c0, input logic [4:0] c1);
      return {c0, c1, 5'b0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_tree_a();
      m1    = 5'd10;
      m2    = 5'd0;
      node0 = mk_node(5'd1, 5'd11);
      node1 = mk_node(5'd2, 5'd12);
      node2 = mk_node(5'd3, 5'd13);
      node3 = mk_node(5'd4, 5'd14);
      node4 = mk_node(5'd5, 5'd15);
      node5 = mk_node(5'd6, 5'd16);
      node6 = mk_node(5'd7, 5'd17);
      node7 = mk_node(5'd8, 5'd9);
   endtask

   // Pulse Start_dec, pass LOAD, land in WALK.
   task automatic do_start();
      start_dec = 1'b1;
      tick();
      start_dec = 1'b0;
      checks++;
      if (sym_valid !== 1'b0 || bit_ready !== 1'b0) begin
         failures++;
         $display("FAIL load_cycle sym_valid=%b bit_ready=%b required 0 0", sym_valid, bit_ready);
      end
      tick();
      checks++;
      if (busy !== 1'b1 || err !== 1'b0 || bit_ready !== 1'b1 || sym_cnt !== 16'd0) begin
         failures++;
         $display("FAIL walk_entry busy=%b err=%b bit_ready=%b cnt=%0d required 1 0 1 0",
                  busy, err, bit_ready, sym_cnt);
      end
   endtask

   // Send bits[0..len-1] in order, first bit first; bounded wait on Bit_ready.
   task automatic send_bits(input logic [8:0] bits, input int len);
      for (int i = 0; i < len; i++) begin
         int waited;
         waited    = 0;
         bit_in    = bits[i];
         bit_valid = 1'b1;
         while (bit_ready !== 1'b1 && waited < 8) begin
            tick();
            waited++;
         end
         checks++;
         if (bit_ready !== 1'b1) begin
            failures++;
            $display("FAIL bit_accept index=%0d bit_ready=%b required 1 within 8 cycles",
                     i, bit_ready);
            bit_valid = 1'b0;
            return;
         end
         tick();
      end
      bit_valid = 1'b0;
   endtask

   // Full code: last bit must be taken at once and the symbol must appear the next cycle.
   task automatic send_code(input logic [8:0] bits, input int len, input logic [3:0] exp_sym);
      if (len > 1) send_bits(bits, len - 1);
      bit_in    = bits[len-1];
      bit_valid = 1'b1;
      checks++;
      if (bit_ready !== 1'b1 || sym_valid !== 1'b0) begin
         failures++;
         $display("FAIL pre_last_bit bit_ready=%b sym_valid=%b required 1 0", bit_ready, sym_valid);
      end
      tick();
      bit_valid = 1'b0;
      checks++;
      if (sym_valid !== 1'b1 || sym_out !== exp_sym) begin
         failures++;
         $display("FAIL symbol sym_valid=%b sym_out=%0d required 1 %0d", sym_valid, sym_out, exp_sym);
      end
`ifdef HUFF_DEC_CODE_LEN_EN
      checks++;
      if (code_len !== 4'(len)) begin
         failures++;
         $display("FAIL code_len got=%0d required=%0d", code_len, len);
      end
`endif
      sym_ready = 1'b1;
      tick();
      sym_ready = 1'b0;
      checks++;
      if (sym_valid !== 1'b0 || bit_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_handshake sym_valid=%b bit_ready=%b required 0 1", sym_valid, bit_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      checks++;
      if (bit_ready !== 1'b0 || sym_out !== 4'd0 || sym_valid !== 1'b0 || busy !== 1'b0 ||
          err !== 1'b0 || sym_cnt !== 16'd0) begin
         failures++;
         $display("FAIL reset_values rdy=%b sym=%0d vld=%b busy=%b err=%b cnt=%0d required all 0",
                  bit_ready, sym_out, sym_valid, busy, err, sym_cnt);
      end
      tick();
      tick();
      rst = 1'b0;
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      tick();
      tick();
      tick();
      bit_valid = 1'b0;
      checks++;
      if (bit_ready !== 1'b0 || sym_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_ignores_bits rdy=%b vld=%b busy=%b required 0 0 0",
                  bit_ready, sym_valid, busy);
      end
   endtask

   task automatic test_decode();
      load_tree_a();
      do_start();
      send_code(9'b000000001, 1, 4'd0);
      send_code(9'b000000000, 2, 4'd1);
      send_code(9'b011111110, 9, 4'd8);
      send_code(9'b111111110, 9, 4'd9);
      checks++;
      if (sym_cnt !== 16'd4) begin
         failures++;
         $display("FAIL decode_count sym_cnt=%0d required 4", sym_cnt);
      end
   endtask

   task automatic test_back_pressure();
      load_tree_a();
      do_start();
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (sym_valid !== 1'b1 || sym_out !== 4'd0 || bit_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold cycle=%0d vld=%b sym=%0d rdy=%b required 1 0 0",
                     i, sym_valid, sym_out, bit_ready);
         end
         tick();
      end
      sym_ready = 1'b1;
      tick();
      sym_ready = 1'b0;
      checks++;
      if (sym_valid !== 1'b0 || bit_ready !== 1'b1 || sym_cnt !== 16'd1) begin
         failures++;
         $display("FAIL bp_release vld=%b rdy=%b cnt=%0d required 0 1 1",
                  sym_valid, bit_ready, sym_cnt);
      end
      tick();
      bit_valid = 1'b0;
      checks++;
      if (sym_valid !== 1'b1 || sym_out !== 4'd0) begin
         failures++;
         $display("FAIL bp_second vld=%b sym=%0d required 1 0", sym_valid, sym_out);
      end
      sym_ready = 1'b1;
      tick();
      sym_ready = 1'b0;
      checks++;
      if (sym_cnt !== 16'd2) begin
         failures++;
         $display("FAIL bp_count sym_cnt=%0d required 2", sym_cnt);
      end
   endtask

   task automatic test_illegal();
      load_tree_a();
      node0 = mk_node(5'd20, 5'd11);
      do_start();
      send_bits(9'b000000000, 2);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || bit_ready !== 1'b0 || sym_valid !== 1'b0) begin
         failures++;
         $display("FAIL illegal_index err=%b busy=%b rdy=%b vld=%b required 1 0 0 0",
                  err, busy, bit_ready, sym_valid);
      end
      load_tree_a();
      do_start();
      send_code(9'b000000000, 2, 4'd1);
   endtask

   task automatic test_over_length();
      load_tree_a();
      node7 = mk_node(5'd12, 5'd13);
      do_start();
      send_bits(9'b011111110, 8);
      checks++;
      if (err !== 1'b0 || bit_ready !== 1'b1) begin
         failures++;
         $display("FAIL depth8_ok err=%b rdy=%b required 0 1", err, bit_ready);
      end
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      tick();
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || bit_ready !== 1'b0 || sym_valid !== 1'b0) begin
         failures++;
         $display("FAIL over_length err=%b busy=%b rdy=%b vld=%b required 1 0 0 0",
                  err, busy, bit_ready, sym_valid);
      end
      tick();
      tick();
      bit_valid = 1'b0;
      checks++;
      if (err !== 1'b1 || bit_ready !== 1'b0) begin
         failures++;
         $display("FAIL err_sticky err=%b rdy=%b required 1 0", err, bit_ready);
      end
   endtask

   task automatic test_abort();
      load_tree_a();
      do_start();
      send_bits(9'b000000010, 2);
      start_dec = 1'b1;
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      tick();
      start_dec = 1'b0;
      bit_valid = 1'b0;
      checks++;
      if (sym_valid !== 1'b0 || bit_ready !== 1'b0) begin
         failures++;
         $display("FAIL abort_mid_code vld=%b rdy=%b required 0 0", sym_valid, bit_ready);
      end
      tick();
      checks++;
      if (sym_cnt !== 16'd0 || bit_ready !== 1'b1) begin
         failures++;
         $display("FAIL abort_reload cnt=%0d rdy=%b required 0 1", sym_cnt, bit_ready);
      end
      send_code(9'b000000001, 1, 4'd0);
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
      start_dec = 1'b1;
      sym_ready = 1'b1;
      tick();
      start_dec = 1'b0;
      sym_ready = 1'b0;
      checks++;
      if (sym_valid !== 1'b0) begin
         failures++;
         $display("FAIL abort_emit vld=%b required 0", sym_valid);
      end
      tick();
      checks++;
      if (sym_cnt !== 16'd0) begin
         failures++;
         $display("FAIL abort_emit_count cnt=%0d required 0", sym_cnt);
      end
   endtask

   task automatic test_reset_mid_emit();
      load_tree_a();
      do_start();
      send_code(9'b000000001, 1, 4'd0);
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bit_ready !== 1'b0 || sym_out !== 4'd0 || sym_valid !== 1'b0 || busy !== 1'b0 ||
          err !== 1'b0 || sym_cnt !== 16'd0) begin
         failures++;
         $display("FAIL async_reset rdy=%b sym=%0d vld=%b busy=%b err=%b cnt=%0d required all 0",
                  bit_ready, sym_out, sym_valid, busy, err, sym_cnt);
      end
      #3;
      rst       = 1'b0;
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      tick();
      tick();
      tick();
      bit_valid = 1'b0;
      checks++;
      if (bit_ready !== 1'b0 || sym_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_idle rdy=%b vld=%b busy=%b required 0 0 0",
                  bit_ready, sym_valid, busy);
      end
      do_start();
      send_code(9'b000000001, 1, 4'd0);
   endtask

   initial begin
      rst       = 1'b1;
      start_dec = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      sym_ready = 1'b0;
      load_tree_a();
      test_reset();
      test_decode();
      test_back_pressure();
      test_illegal();
      test_over_length();
      test_abort();
      test_reset_mid_emit();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
